fetch_unit: RTL and testbench

Instruction fetch stage for the 8-bit core. It owns the 4-bit program counter, drives the address of the combinational instruction memory and captures the returned byte into an instruction register. It hands that instruction to the decode stage over a valid/ready handshake. It also handles decode-requested jumps and halts on the HLT opcode.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/program_counter.sv | 37 +++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int ADDR_W_DEF  = 4;
   localparam int INSTR_W_DEF = 8;

   localparam logic [3:0] OPC_HLT = 4'hF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      HOLD   = 2'd2,
      HALTED = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter register; load wins over inc, wraps modulo 2^ADDR_W.
module program_counter
   import fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = load_addr;
      end else if (inc) begin
         pc_d = pc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register, valid/ready
// hand-off to decode, jump redirect and halt on HLT.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [INSTR_W-1:0] mem_instr,
   output logic [INSTR_W-1:0] ir_data,
   output logic [ADDR_W-1:0]  ir_pc,
   output logic               ir_valid,
   input  logic               ir_ready,
   input  logic               jump_en,
   input  logic [ADDR_W-1:0]  jump_addr,
   output logic               halted,
   output logic [7:0]         retired
);

   fetch_state_t       state_q, state_d;
   logic [INSTR_W-1:0] ir_data_q, ir_data_d;
   logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
   logic               ir_valid_q, ir_valid_d;
   logic               halted_q, halted_d;
   logic [7:0]         retired_q, retired_d;

   logic [ADDR_W-1:0] pc;
   logic              pc_inc;
   logic              pc_load;
   logic              hs;
   logic              is_hlt;

   program_counter #(.ADDR_W(ADDR_W)) u_pc (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (pc_inc),
      .load      (pc_load),
      .load_addr (jump_addr),
      .pc        (pc)
   );

   assign hs     = ir_valid_q && ir_ready;
   assign is_hlt = (ir_data_q[INSTR_W-1 -: 4] == OPC_HLT);

   always_comb begin
      state_d    = state_q;
      ir_data_d  = ir_data_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;
      halted_d   = halted_q;
      retired_d  = retired_q;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (run) state_d = FETCH;
         end
         FETCH: begin
            if (run) begin
               ir_data_d  = mem_instr;
               ir_pc_d    = pc;
               ir_valid_d = 1'b1;
               pc_inc     = 1'b1;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            if (hs) begin
               if (retired_q != 8'hFF) retired_d = retired_q + 8'd1;
               if (is_hlt) begin
                  ir_valid_d = 1'b0;
                  halted_d   = 1'b1;
                  state_d    = HALTED;
               end else if (jump_en) begin
                  // redirect costs one bubble: refetch in FETCH
                  pc_load    = 1'b1;
                  ir_valid_d = 1'b0;
                  state_d    = FETCH;
               end else begin
                  ir_data_d = mem_instr;
                  ir_pc_d   = pc;
                  pc_inc    = 1'b1;
               end
            end
         end
         HALTED: ;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ir_data_q  <= '0;
         ir_pc_q    <= '0;
         ir_valid_q <= 1'b0;
         halted_q   <= 1'b0;
         retired_q  <= '0;
      end else begin
         state_q    <= state_d;
         ir_data_q  <= ir_data_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
         halted_q   <= halted_d;
         retired_q  <= retired_d;
      end
   end

   assign mem_addr = pc;
   assign ir_data  = ir_data_q;
   assign ir_pc    = ir_pc_q;
   assign ir_valid = ir_valid_q;
   assign halted   = halted_q;
   assign retired  = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, hand sequences
// and a randomized run against a transaction-level model.
module tb_fetch_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic       ir_ready = 1'b0;
   logic       jump_en = 1'b0;
   logic [3:0] jump_addr = 4'h0;
   logic [3:0] mem_addr;
   logic [7:0] mem_instr;
   logic [7:0] ir_data;
   logic [3:0] ir_pc;
   logic       ir_valid;
   logic       halted;
   logic [7:0] retired;

   logic [7:0] mem [16];
   assign mem_instr = mem[mem_addr];

   fetch_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .mem_addr  (mem_addr),
      .mem_instr (mem_instr),
      .ir_data   (ir_data),
      .ir_pc     (ir_pc),
      .ir_valid  (ir_valid),
      .ir_ready  (ir_ready),
      .jump_en   (jump_en),
      .jump_addr (jump_addr),
      .halted    (halted),
      .retired   (retired)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic ev,
                          input logic eh, input logic [3:0] ipc,
                          input logic [7:0] d, input logic [7:0] ret,
                          input logic [3:0] ma);
      chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(ev));
      chk({tag, ".halted"},   32'(halted),   32'(eh));
      chk({tag, ".ir_pc"},    32'(ir_pc),    32'(ipc));
      chk({tag, ".ir_data"},  32'(ir_data),  32'(d));
      chk({tag, ".retired"},  32'(retired),  32'(ret));
      chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(ma));
   endtask

   // ---------------- reference model ----------------
   bit         m_started, m_valid, m_halted;
   logic [3:0] m_pc, m_ipc;
   logic [7:0] m_data;
   int         m_ret;

   task automatic model_reset();
      m_started = 0; m_valid = 0; m_halted = 0;
      m_pc = 0; m_ipc = 0; m_data = 0; m_ret = 0;
   endtask

   task automatic model_capture();
      m_data  = mem[m_pc];
      m_ipc   = m_pc;
      m_pc    = 4'((int'(m_pc) + 1) % 16);
      m_valid = 1;
   endtask

   task automatic model_step();
      if (m_halted) return;
      if (!m_started) begin
         if (run) m_started = 1;
      end else if (!m_valid) begin
         if (run) model_capture();
      end else if (ir_ready) begin
         m_ret = (m_ret < 255) ? m_ret + 1 : 255;
         if (m_data[7:4] == 4'hF) begin
            m_valid = 0; m_halted = 1;
         end else if (jump_en) begin
            m_pc = jump_addr; m_valid = 0;
         end else begin
            model_capture();
         end
      end
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic       run, rdy, je;
      logic [3:0] ja;
      logic       ev, eh;
      logic [3:0] ipc;
      logic [7:0] d;
      logic [7:0] ret;
      logic [3:0] ma;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic rd, input logic j,
                      input logic [3:0] ja, input logic ev,
                      input logic eh, input logic [3:0] ipc,
                      input logic [7:0] d, input logic [7:0] ret,
                      input logic [3:0] ma);
      vec_t v;
      v.run = r; v.rdy = rd; v.je = j; v.ja = ja;
      v.ev = ev; v.eh = eh; v.ipc = ipc; v.d = d;
      v.ret = ret; v.ma = ma;
      tbl.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; run = 0; ir_ready = 0; jump_en = 0;
      model_reset();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      foreach (mem[i]) mem[i] = 8'h01;
      mem[0] = 8'h00; mem[1] = 8'h10; mem[2] = 8'h04;
      mem[3] = 8'hF0; mem[12] = 8'h20; mem[13] = 8'h31;
      mem[14] = 8'h42; mem[15] = 8'h53;

      //   run rdy je ja   ev eh ipc d      ret ma
      add(1, 0, 0, 0,    0, 0, 0,  8'h00, 0,  0);
      add(1, 0, 0, 0,    1, 0, 0,  8'h00, 0,  1);
      add(0, 1, 0, 0,    1, 0, 1,  8'h10, 1,  2);
      add(0, 0, 0, 0,    1, 0, 1,  8'h10, 1,  2);
      add(0, 0, 1, 5,    1, 0, 1,  8'h10, 1,  2);
      add(1, 0, 0, 0,    1, 0, 1,  8'h10, 1,  2);
      add(0, 0, 1, 9,    1, 0, 1,  8'h10, 1,  2);
      add(0, 0, 0, 0,    1, 0, 1,  8'h10, 1,  2);
      add(0, 1, 0, 0,    1, 0, 2,  8'h04, 2,  3);
      add(0, 1, 1, 12,   0, 0, 2,  8'h04, 3,  12);
      add(1, 1, 0, 0,    1, 0, 12, 8'h20, 3,  13);
      add(0, 1, 0, 0,    1, 0, 13, 8'h31, 4,  14);
      add(0, 1, 0, 0,    1, 0, 14, 8'h42, 5,  15);
      add(0, 1, 0, 0,    1, 0, 15, 8'h53, 6,  0);
      add(0, 1, 0, 0,    1, 0, 0,  8'h00, 7,  1);
      add(0, 1, 0, 0,    1, 0, 1,  8'h10, 8,  2);
      add(0, 1, 0, 0,    1, 0, 2,  8'h04, 9,  3);
      add(0, 1, 0, 0,    1, 0, 3,  8'hF0, 10, 4);
      add(0, 1, 1, 7,    0, 1, 3,  8'hF0, 11, 4);
      add(1, 1, 1, 2,    0, 1, 3,  8'hF0, 11, 4);
      add(1, 1, 0, 0,    0, 1, 3,  8'hF0, 11, 4);

      tick();
      tick();
      chk_all("reset", 0, 0, 0, 8'h00, 0, 0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         run = tbl[i].run; ir_ready = tbl[i].rdy;
         jump_en = tbl[i].je; jump_addr = tbl[i].ja;
         tick();
         chk_all($sformatf("row%0d", i), tbl[i].ev, tbl[i].eh,
                 tbl[i].ipc, tbl[i].d, tbl[i].ret, tbl[i].ma);
      end

      // asynchronous reset between edges while streaming
      do_reset();
      run = 1; ir_ready = 1; jump_en = 0;
      repeat (4) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 0, 0, 0, 8'h00, 0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run = 1; ir_ready = 1;
      tick();
      chk_all("restart0", 0, 0, 0, 8'h00, 0, 0);
      tick();
      chk_all("restart1", 1, 0, 0, 8'h00, 0, 1);

      // retired saturation
      foreach (mem[i]) mem[i] = 8'h01;
      do_reset();
      run = 1; ir_ready = 1;
      repeat (302) tick();
      chk("sat.retired", 32'(retired), 32'd255);
      chk("sat.ir_valid", 32'(ir_valid), 32'd1);

      // randomized run against the model
      for (int s = 0; s < 6; s++) begin
         foreach (mem[i])
            mem[i] = ($urandom_range(0, 24) == 0) ? 8'hF0
                   : 8'($urandom_range(0, 8'hEF));
         do_reset();
         for (int c = 0; c < 400; c++) begin
            run       = ($urandom_range(0, 3) != 0);
            ir_ready  = ($urandom_range(0, 2) != 0);
            jump_en   = ($urandom_range(0, 5) == 0);
            jump_addr = 4'($urandom);
            model_step();
            tick();
            chk_all($sformatf("rnd%0d_%0d", s, c), m_valid, m_halted,
                    m_ipc, m_data, 8'(m_ret), m_pc);
            if (m_halted && $urandom_range(0, 3) == 0) do_reset();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
